// File: rtl/isa_pkg.sv
// Shared ISA constants for the 9-bit CPU: widths, opcode
// fields, opcode/special sub-codes and fetch FSM states.
package isa_pkg;

  localparam int PC_W    = 8;
  localparam int INSTR_W = 9;
  localparam int BOFS_W  = 5;
  localparam int OPC_MSB = 8;
  localparam int OPC_LSB = 5;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_LD   = 4'd1;
  localparam logic [3:0] OP_ST   = 4'd2;
  localparam logic [3:0] OP_SL   = 4'd3;
  localparam logic [3:0] OP_SR   = 4'd4;
  localparam logic [3:0] OP_STT  = 4'd5;
  localparam logic [3:0] OP_STF  = 4'd6;
  localparam logic [3:0] OP_SPEC = 4'd7;
  localparam logic [3:0] OP_SWP  = 4'd8;
  localparam logic [3:0] OP_STL  = 4'd9;
  localparam logic [3:0] OP_STH  = 4'd10;
  localparam logic [3:0] OP_BEQ  = 4'd11;
  localparam logic [3:0] OP_BLT  = 4'd12;
  localparam logic [3:0] OP_JMP  = 4'd13;

  localparam logic [4:0] SP_INC = 5'd0;
  localparam logic [4:0] SP_AON = 5'd1;
  localparam logic [4:0] SP_HLT = 5'd2;
  localparam logic [4:0] SP_SEG = 5'd3;
  localparam logic [4:0] SP_PKR = 5'd4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    EXEC   = 2'd2,
    HALTED = 2'd3
  } fetch_state_t;

  function automatic logic [3:0] opcode_of(
    input logic [INSTR_W-1:0] instr
  );
    return instr[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Fetch bus: instruction-memory port plus decoder controls.
// master = fetch_sequencer, slave = memory/decoder side.
interface fetch_sequencer_if;
  import isa_pkg::*;

  logic [PC_W-1:0]    imem_addr;
  logic               imem_en;
  logic [INSTR_W-1:0] imem_data;
  logic [INSTR_W-1:0] instruction;
  logic               instr_valid;
  logic               branch;
  logic               branch_cond;
  logic               jmp_ctrl;
  logic [PC_W-1:0]    jmp_target;
  logic               done_ctrl;

  modport master (
    output imem_addr, imem_en,
    output instruction, instr_valid,
    input  imem_data,
    input  branch, branch_cond,
    input  jmp_ctrl, jmp_target,
    input  done_ctrl
  );

  modport slave (
    input  imem_addr, imem_en,
    input  instruction, instr_valid,
    output imem_data,
    output branch, branch_cond,
    output jmp_ctrl, jmp_target,
    output done_ctrl
  );

endinterface

// File: rtl/pc_next_calc.sv
// Next-PC selection, combinational. Ports: pc, ofs, control
// inputs, jmp_target in; pc_next out (modulo 2^PC_W).
module pc_next_calc #(
  parameter int PC_W   = 8,
  parameter int BOFS_W = 5
) (
  input  logic [PC_W-1:0]   pc,
  input  logic [BOFS_W-1:0] ofs,
  input  logic              branch,
  input  logic              branch_cond,
  input  logic              jmp_ctrl,
  input  logic [PC_W-1:0]   jmp_target,
  input  logic              done_ctrl,
  output logic [PC_W-1:0]   pc_next
);

  logic [PC_W-1:0] ofs_sx;

  assign ofs_sx = {{(PC_W-BOFS_W){ofs[BOFS_W-1]}}, ofs};

  // Halt > jump > taken branch > sequential.
  always_comb begin
    pc_next = pc + 1'b1;
    if (done_ctrl)
      pc_next = pc;
    else if (jmp_ctrl)
      pc_next = jmp_target;
    else if (branch && branch_cond)
      pc_next = pc + ofs_sx;
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch/sequencing front end: owns PC, fetches, hands words
// to the decoder. Ports: clock, reset, start, bus (master),
// pc, done; cycle_count when CYCLE_COUNT_EN is defined.
module fetch_sequencer
  import isa_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  fetch_sequencer_if.master bus,
  output logic [PC_W-1:0] pc,
`ifdef CYCLE_COUNT_EN
  output logic [15:0]     cycle_count,
`endif
  output logic            done
);

  fetch_state_t       state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d, pc_calc;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               accept;

  pc_next_calc #(
    .PC_W   (PC_W),
    .BOFS_W (BOFS_W)
  ) u_pc_next (
    .pc          (pc_q),
    .ofs         (instr_q[BOFS_W-1:0]),
    .branch      (bus.branch),
    .branch_cond (bus.branch_cond),
    .jmp_ctrl    (bus.jmp_ctrl),
    .jmp_target  (bus.jmp_target),
    .done_ctrl   (bus.done_ctrl),
    .pc_next     (pc_calc)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    instr_d         = instr_q;
    accept          = 1'b0;
    bus.imem_en     = 1'b0;
    bus.instr_valid = 1'b0;
    done            = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          pc_d    = '0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        bus.imem_en = 1'b1;
        instr_d     = bus.imem_data;
        state_d     = EXEC;
      end
      EXEC: begin
        bus.instr_valid = 1'b1;
        pc_d            = pc_calc;
        state_d = bus.done_ctrl ? HALTED : FETCH;
      end
      HALTED: begin
        done = 1'b1;
        if (start) begin
          accept  = 1'b1;
          pc_d    = '0;
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.imem_addr   = pc_q;
  assign bus.instruction = instr_q;
  assign pc              = pc_q;

`ifdef CYCLE_COUNT_EN
  logic [15:0] cnt_q;
  logic        busy;

  assign busy = (state_q == FETCH) || (state_q == EXEC);

  always_ff @(posedge clock) begin
    if (reset)
      cnt_q <= '0;
    else if (accept)
      cnt_q <= '0;
    else if (busy && cnt_q != 16'hFFFF)
      cnt_q <= cnt_q + 16'd1;
  end

  assign cycle_count = cnt_q;
`endif

endmodule
